// File: rtl/data_mem_responder_if.sv
// data_mem_responder_if: LSU data bus between the memory-stage initiator and its target
interface data_mem_responder_if;
  logic        data_req;
  logic        data_wr;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic [3:0]  data_byteen;
  logic        data_gnt;
  logic [31:0] data_rdata;
  logic        data_valid;
  logic        data_err;
  modport master (
    output data_req, data_wr, data_addr, data_wdata, data_byteen,
    input  data_gnt, data_rdata, data_valid, data_err
  );
  modport slave (
    input  data_req, data_wr, data_addr, data_wdata, data_byteen,
    output data_gnt, data_rdata, data_valid, data_err
  );
endinterface

// File: rtl/data_mem_responder.sv
// data_mem_responder: byte-enabled data RAM target for the LSU bus with fixed-latency responses
module data_mem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY = 1,
  parameter int STALL_EVERY = 0,
  localparam int AW = $clog2(DEPTH_WORDS)
) (
  input logic clk,
  input logic reset_n,
  data_mem_responder_if.slave bus
);
  logic [31:0] mem [DEPTH_WORDS];
  logic stall_q;
  logic grant;
  logic oor;
  logic [AW-1:0] widx;
  logic [31:0] rd;
  logic v_q [LATENCY];
  logic e_q [LATENCY];
  logic [31:0] d_q [LATENCY];
  logic unused_addr_lsb;
  if (LATENCY < 1 || LATENCY > 4) begin : g_bad_latency
    $error("LATENCY must be 1..4");
  end
  assign bus.data_gnt = bus.data_req & ~stall_q;
  assign grant = bus.data_req & bus.data_gnt;
  assign oor = |bus.data_addr[31:AW+2];
  assign widx = bus.data_addr[AW+1:2];
  assign rd = (bus.data_wr | oor) ? '0 : mem[widx];
  assign unused_addr_lsb = ^bus.data_addr[1:0];
  always_ff @(posedge clk)
    if (grant & bus.data_wr & ~oor)
      for (int b = 0; b < 4; b++)
        if (bus.data_byteen[b]) mem[widx][8*b +: 8] <= bus.data_wdata[8*b +: 8];
  // loads sample the RAM before this edge's write, so a store only becomes visible to later grants
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      for (int i = 0; i < LATENCY; i++) begin
        v_q[i] <= 1'b0;
        e_q[i] <= 1'b0;
        d_q[i] <= '0;
      end
    end else begin
      v_q[0] <= grant;
      e_q[0] <= grant & oor;
      d_q[0] <= grant ? rd : '0;
      for (int i = 1; i < LATENCY; i++) begin
        v_q[i] <= v_q[i-1];
        e_q[i] <= e_q[i-1];
        d_q[i] <= d_q[i-1];
      end
    end
  assign bus.data_valid = v_q[LATENCY-1];
  assign bus.data_err = e_q[LATENCY-1];
  assign bus.data_rdata = d_q[LATENCY-1];
  if (STALL_EVERY > 0) begin : g_stall
    localparam int CW = STALL_EVERY > 1 ? $clog2(STALL_EVERY) : 1;
    logic [CW-1:0] gcnt;
    logic wrap;
    assign wrap = gcnt == CW'(STALL_EVERY - 1);
    always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
        stall_q <= 1'b0;
        gcnt <= '0;
      end else begin
        stall_q <= grant & wrap;
        if (grant) gcnt <= wrap ? '0 : gcnt + 1'b1;
      end
  end else begin : g_nostall
    assign stall_q = 1'b0;
  end
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: vector table, directed corner sequences and a model-checked random run
module tb_data_mem_responder;
  logic clk;
  logic reset_n;
  logic rn_d;
  int n_cmp;
  int n_bad;
  data_mem_responder_if ia();
  data_mem_responder_if ib();
  data_mem_responder_if ic();
  data_mem_responder_if id();
  data_mem_responder #(.LATENCY(1)) ua (.clk(clk), .reset_n(reset_n), .bus(ia));
  data_mem_responder #(.LATENCY(3)) ub (.clk(clk), .reset_n(reset_n), .bus(ib));
  data_mem_responder #(.LATENCY(1), .STALL_EVERY(2)) uc (.clk(clk), .reset_n(reset_n), .bus(ic));
  data_mem_responder #(.DEPTH_WORDS(16), .LATENCY(2), .STALL_EVERY(3)) ud (.clk(clk), .reset_n(rn_d), .bus(id));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  typedef struct {
    logic wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0] be;
    logic err;
    logic [31:0] rdata;
  } vec_t;
  typedef struct {
    int due;
    logic err;
    logic [31:0] rd;
  } rsp_t;
  vec_t tv[17];
  rsp_t q[$];
  rsp_t r;
  logic [31:0] mm[16];
  int rq_pat[11] = '{1, 1, 1, 1, 1, 1, 1, 0, 0, 1, 1};
  int gn_pat[11] = '{1, 1, 0, 1, 1, 0, 1, 0, 0, 1, 0};
  logic have, rq_wr, stall_m, exp_v, sent;
  logic [31:0] rq_addr, rq_wd;
  logic [3:0] rq_be;
  int ngr, pre, nval;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  initial begin
    n_cmp = 0;
    n_bad = 0;
    {ia.data_req, ia.data_wr, ia.data_addr, ia.data_wdata, ia.data_byteen} = '0;
    {ib.data_req, ib.data_wr, ib.data_addr, ib.data_wdata, ib.data_byteen} = '0;
    {ic.data_req, ic.data_wr, ic.data_addr, ic.data_wdata, ic.data_byteen} = '0;
    {id.data_req, id.data_wr, id.data_addr, id.data_wdata, id.data_byteen} = '0;
    reset_n = 1'b0;
    rn_d = 1'b0;
    tv[0]  = '{1'b1, 32'h10,       32'hAABBCCDD, 4'hF, 1'b0, 32'h0};
    tv[1]  = '{1'b0, 32'h10,       32'h0,        4'hF, 1'b0, 32'hAABBCCDD};
    tv[2]  = '{1'b1, 32'h10,       32'h00005500, 4'h2, 1'b0, 32'h0};
    tv[3]  = '{1'b0, 32'h10,       32'h0,        4'hF, 1'b0, 32'hAABB55DD};
    tv[4]  = '{1'b1, 32'h0,        32'h11223344, 4'hF, 1'b0, 32'h0};
    tv[5]  = '{1'b0, 32'h1000,     32'h0,        4'hF, 1'b1, 32'h0};
    tv[6]  = '{1'b1, 32'h1000,     32'hFFFFFFFF, 4'hF, 1'b1, 32'h0};
    tv[7]  = '{1'b0, 32'h0,        32'h0,        4'hF, 1'b0, 32'h11223344};
    tv[8]  = '{1'b1, 32'h13,       32'h99000000, 4'h8, 1'b0, 32'h0};
    tv[9]  = '{1'b0, 32'h12,       32'h0,        4'h0, 1'b0, 32'h99BB55DD};
    tv[10] = '{1'b1, 32'h10,       32'h0,        4'h0, 1'b0, 32'h0};
    tv[11] = '{1'b0, 32'h10,       32'h0,        4'hF, 1'b0, 32'h99BB55DD};
    tv[12] = '{1'b1, 32'hFFC,      32'hCAFEF00D, 4'hF, 1'b0, 32'h0};
    tv[13] = '{1'b0, 32'hFFF,      32'h0,        4'hF, 1'b0, 32'hCAFEF00D};
    tv[14] = '{1'b0, 32'h80000000, 32'h0,        4'hF, 1'b1, 32'h0};
    tv[15] = '{1'b1, 32'h80000010, 32'hAAAAAAAA, 4'hF, 1'b1, 32'h0};
    tv[16] = '{1'b0, 32'h10,       32'h0,        4'hF, 1'b0, 32'h99BB55DD};
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", ia.data_valid, 0);
    chk("rst_rdata", ia.data_rdata, 0);
    chk("rst_err", ia.data_err, 0);
    chk("rst_valid_d", id.data_valid, 0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    rn_d = 1'b1;
    for (int i = 0; i < 17; i++) begin
      @(posedge clk); #1;
      {ia.data_req, ia.data_wr, ia.data_addr, ia.data_wdata, ia.data_byteen} =
        {1'b1, tv[i].wr, tv[i].addr, tv[i].wdata, tv[i].be};
      @(negedge clk);
      chk($sformatf("v%0d_gnt", i), ia.data_gnt, 1);
      chk($sformatf("v%0d_idle", i), ia.data_valid, 0);
      @(posedge clk); #1;
      ia.data_req = 1'b0;
      @(negedge clk);
      chk($sformatf("v%0d_valid", i), ia.data_valid, 1);
      chk($sformatf("v%0d_err", i), ia.data_err, tv[i].err);
      chk($sformatf("v%0d_rdata", i), ia.data_rdata, tv[i].rdata);
    end
    // store then load the same word on consecutive grants
    @(posedge clk); #1;
    {ia.data_req, ia.data_wr, ia.data_addr, ia.data_wdata, ia.data_byteen} = {1'b1, 1'b1, 32'h20, 32'hDEADBEEF, 4'hF};
    @(negedge clk);
    chk("haz_gnt_st", ia.data_gnt, 1);
    @(posedge clk); #1;
    ia.data_wr = 1'b0;
    @(negedge clk);
    chk("haz_gnt_ld", ia.data_gnt, 1);
    chk("haz_valid_st", ia.data_valid, 1);
    chk("haz_rdata_st", ia.data_rdata, 0);
    @(posedge clk); #1;
    ia.data_req = 1'b0;
    @(negedge clk);
    chk("haz_valid_ld", ia.data_valid, 1);
    chk("haz_rdata_ld", ia.data_rdata, 32'hDEADBEEF);
    @(negedge clk);
    chk("haz_pulse_end", ia.data_valid, 0);
    // LATENCY=3 ordering
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      {ib.data_req, ib.data_wr, ib.data_addr, ib.data_wdata, ib.data_byteen} = {1'b1, 1'b1, 32'(4 * c), 32'(c + 1), 4'hF};
    end
    @(posedge clk); #1;
    ib.data_req = 1'b0;
    repeat (5) @(posedge clk);
    for (int c = 0; c < 9; c++) begin
      @(posedge clk); #1;
      {ib.data_req, ib.data_wr, ib.data_addr, ib.data_byteen} = {c < 4, 1'b0, 32'(4 * c), 4'hF};
      @(negedge clk);
      chk($sformatf("l3_gnt%0d", c), ib.data_gnt, c < 4);
      chk($sformatf("l3_valid%0d", c), ib.data_valid, c >= 3 && c <= 6);
      if (c >= 3 && c <= 6) chk($sformatf("l3_rdata%0d", c), ib.data_rdata, 32'(c - 2));
    end
    // STALL_EVERY=2 grant pattern, including idle cycles that must not advance the count
    nval = 0;
    for (int c = 0; c < 13; c++) begin
      @(posedge clk); #1;
      {ic.data_req, ic.data_wr, ic.data_addr, ic.data_byteen} = {c < 11 && rq_pat[c % 11] == 1, 1'b0, 32'h0, 4'hF};
      @(negedge clk);
      if (c < 11) chk($sformatf("stall_gnt%0d", c), ic.data_gnt, gn_pat[c]);
      if (ic.data_valid) nval++;
      if (c == 6) chk("stall_valid6", nval, 4);
    end
    chk("stall_valid_total", nval, 6);
    // randomized run against the reference model
    have = 1'b0;
    stall_m = 1'b0;
    ngr = 0;
    pre = 0;
    for (int c = 0; c < 600; c++) begin
      @(posedge clk); #1;
      if (!have && c < 590) begin
        if (pre < 16) begin
          {have, rq_wr, rq_addr, rq_wd, rq_be} = {1'b1, 1'b1, 32'(4 * pre), $urandom(), 4'hF};
          pre++;
        end else if ($urandom_range(0, 9) < 7) begin
          have = 1'b1;
          rq_wr = $urandom_range(0, 1) == 1;
          rq_addr = $urandom_range(0, 9) == 0 ? ($urandom() | 32'h100) : 32'($urandom_range(0, 63));
          rq_wd = $urandom();
          rq_be = 4'($urandom());
        end
      end
      {id.data_req, id.data_wr, id.data_addr, id.data_wdata, id.data_byteen} = {have, rq_wr, rq_addr, rq_wd, rq_be};
      @(negedge clk);
      exp_v = q.size() > 0 && q[0].due == c;
      chk("rnd_valid", id.data_valid, exp_v);
      if (exp_v) begin
        r = q.pop_front();
        chk("rnd_err", id.data_err, r.err);
        chk("rnd_rdata", id.data_rdata, r.rd);
      end
      chk("rnd_gnt", id.data_gnt, have && !stall_m);
      if (have && !stall_m) begin
        r.due = c + 2;
        r.err = rq_addr >= 64;
        r.rd = (rq_wr || r.err) ? 32'h0 : mm[rq_addr[5:2]];
        if (rq_wr && !r.err)
          for (int b = 0; b < 4; b++)
            if (rq_be[b]) mm[rq_addr[5:2]][8*b +: 8] = rq_wd[8*b +: 8];
        q.push_back(r);
        ngr++;
        stall_m = ngr % 3 == 0;
        have = 1'b0;
      end else begin
        stall_m = 1'b0;
      end
    end
    chk("rnd_drained", q.size(), 0);
    // reset one cycle after a granted store
    sent = 1'b0;
    for (int k = 0; k < 4 && !sent; k++) begin
      @(posedge clk); #1;
      {id.data_req, id.data_wr, id.data_addr, id.data_wdata, id.data_byteen} = {1'b1, 1'b1, 32'h14, 32'h5A5A5A5A, 4'hF};
      @(negedge clk);
      sent = id.data_gnt;
    end
    chk("rst_store_gnt", sent, 1);
    @(posedge clk); #1;
    id.data_req = 1'b0;
    rn_d = 1'b0;
    @(posedge clk); #1;
    rn_d = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk($sformatf("rst_novalid%0d", c), id.data_valid, 0);
    end
    @(posedge clk); #1;
    {id.data_req, id.data_wr, id.data_addr, id.data_byteen} = {1'b1, 1'b0, 32'h14, 4'hF};
    @(negedge clk);
    chk("rst_load_gnt", id.data_gnt, 1);
    @(posedge clk); #1;
    id.data_req = 1'b0;
    @(negedge clk);
    chk("rst_load_wait", id.data_valid, 0);
    @(negedge clk);
    chk("rst_load_valid", id.data_valid, 1);
    chk("rst_load_rdata", id.data_rdata, 32'h5A5A5A5A);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
